// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed common-anode seven-segment driver with a prescaled
// refresh scan, double-buffered display data and leading-zero blanking.
module seg7_scan #(
  parameter int NDIG = 8,
  parameter int DIV  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp,
  input  logic              blank_lz,
  output logic [NDIG-1:0]   digit,
  output logic [7:0]        segment,
  output logic              frame
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NDIG - 1);

  logic [PW-1:0]     p_q, p_d;
  logic [IW-1:0]     i_q, i_d;
  logic              first_q, first_d;
  logic [4*NDIG-1:0] pendValue_q, pendValue_d;
  logic [NDIG-1:0]   pendDp_q, pendDp_d;
  logic              pendBlank_q, pendBlank_d;
  logic [4*NDIG-1:0] actValue_q, actValue_d;
  logic [NDIG-1:0]   actDp_q, actDp_d;
  logic              actBlank_q, actBlank_d;
  logic [NDIG-1:0]   digit_q, digit_d;
  logic [7:0]        segment_q, segment_d;
  logic              frame_q, frame_d;

  logic [3:0]        curNib;
  logic              curDp;
  logic              curZeroFrom;
  logic              zeroRun;
  logic              blanked;
  logic [7:0]        curSeg;

  function automatic logic [7:0] decodeHex(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    p_d     = p_q;
    i_d     = i_q;
    first_d = first_q;
    if (enable) begin
      first_d = 1'b0;
      if (p_q == PMAX) begin
        p_d = '0;
        i_d = (i_q == IMAX) ? '0 : i_q + IW'(1);
      end else begin
        p_d = p_q + PW'(1);
      end
    end
  end

  // The transfer fires on the edge after the frame pulse (a dead-time clock),
  // so a load landing on that same edge bypasses pending straight into active.
  always_comb begin
    pendValue_d = load ? value : pendValue_q;
    pendDp_d    = load ? dp : pendDp_q;
    pendBlank_d = load ? blank_lz : pendBlank_q;
    actValue_d  = actValue_q;
    actDp_d     = actDp_q;
    actBlank_d  = actBlank_q;
    if (frame_q) begin
      actValue_d = pendValue_d;
      actDp_d    = pendDp_d;
      actBlank_d = pendBlank_d;
    end
  end

  always_comb begin
    curNib      = 4'h0;
    curDp       = 1'b0;
    curZeroFrom = 1'b0;
    zeroRun     = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      zeroRun = zeroRun & (actValue_d[4*k +: 4] == 4'h0);
      if (IW'(k) == i_q) begin
        curNib      = actValue_d[4*k +: 4];
        curDp       = actDp_d[k];
        curZeroFrom = zeroRun;
      end
    end
    blanked = actBlank_d && (i_q != '0) && curZeroFrom;
    curSeg  = blanked ? 8'hFF : decodeHex(curNib);
    if (curDp) curSeg[0] = 1'b0;
  end

  // The first clock of each slot is kept dark to stop ghosting between digits.
  always_comb begin
    digit_d   = '1;
    segment_d = 8'hFF;
    frame_d   = 1'b0;
    if (enable) begin
      if (p_q == '0) begin
        frame_d = (i_q == '0) && !first_q;
      end else begin
        for (int k = 0; k < NDIG; k++) digit_d[k] = (IW'(k) != i_q);
        segment_d = curSeg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      i_q         <= '0;
      first_q     <= 1'b1;
      pendValue_q <= '0;
      pendDp_q    <= '0;
      pendBlank_q <= 1'b0;
      actValue_q  <= '0;
      actDp_q     <= '0;
      actBlank_q  <= 1'b0;
      digit_q     <= '1;
      segment_q   <= 8'hFF;
      frame_q     <= 1'b0;
    end else begin
      p_q         <= p_d;
      i_q         <= i_d;
      first_q     <= first_d;
      pendValue_q <= pendValue_d;
      pendDp_q    <= pendDp_d;
      pendBlank_q <= pendBlank_d;
      actValue_q  <= actValue_d;
      actDp_q     <= actDp_d;
      actBlank_q  <= actBlank_d;
      digit_q     <= digit_d;
      segment_q   <= segment_d;
      frame_q     <= frame_d;
    end
  end

  assign digit   = digit_q;
  assign segment = segment_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scenario tasks plus randomized traffic for seg7_scan (NDIG=4,
// DIV=4), checked against a frame-arithmetic reference model.
module tb_seg7_scan;
  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  digit;
  logic [7:0]  segment;
  logic        frame;

  int checks = 0;
  int failures = 0;

  logic [7:0] segTab [16];

  int          n;
  int          mp;
  int          mi;
  logic [15:0] pendV, actV;
  logic [3:0]  pendDp, actDp;
  logic        pendB, actB;
  logic [3:0]  expDigit;
  logic [7:0]  expSeg;
  logic        expFrame;

  seg7_scan #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
    .dp(dp), .blank_lz(blank_lz), .digit(digit), .segment(segment), .frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] refSeg(logic [15:0] v, logic [3:0] d, logic b, int idx);
    logic [15:0] upper;
    logic [7:0]  s;
    upper = v >> (4 * idx);
    if (b && idx > 0 && upper == 16'h0) s = 8'hFF;
    else s = segTab[upper[3:0]];
    if (d[idx]) s[0] = 1'b0;
    return s;
  endfunction

  // Model: n counts enabled clocks since reset; slot and digit follow by division.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0;
      pendV = 16'h0; pendDp = 4'h0; pendB = 1'b0;
      actV = 16'h0; actDp = 4'h0; actB = 1'b0;
      expDigit = 4'hF; expSeg = 8'hFF; expFrame = 1'b0;
    end else begin
      if (load) begin pendV = value; pendDp = dp; pendB = blank_lz; end
      if (expFrame) begin actV = pendV; actDp = pendDp; actB = pendB; end
      if (!enable) begin
        expDigit = 4'hF; expSeg = 8'hFF; expFrame = 1'b0;
      end else begin
        mp = n % DIV;
        mi = (n / DIV) % NDIG;
        if (mp == 0) begin
          expDigit = 4'hF; expSeg = 8'hFF; expFrame = (mi == 0) && (n != 0);
        end else begin
          expDigit = 4'hF; expDigit[mi] = 1'b0;
          expSeg = refSeg(actV, actDp, actB, mi); expFrame = 1'b0;
        end
        n = n + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitFrame(output bit seen);
    seen = 1'b0;
    for (int w = 0; w < 4 * FRAME; w++) begin
      if (frame === 1'b1) seen = 1'b1;
      if (!seen) tick();
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (digit !== 4'hF || segment !== 8'hFF || frame !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_state digit=%h seg=%h frame=%b want digit=f seg=ff frame=0", digit, segment, frame);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_pattern();
    int lastF = -1;
    value = 16'h1234; dp = 4'h0; blank_lz = 1'b0; load = 1'b1;
    for (int c = 0; c < 4 * FRAME; c++) begin
      tick();
      load = 1'b0;
      checks++;
      if (digit !== expDigit || segment !== expSeg || frame !== expFrame) begin
        failures++;
        $display("[TB] FAIL pattern c=%0d digit=%h seg=%h frame=%b want %h %h %b", c, digit, segment, frame, expDigit, expSeg, expFrame);
      end
      if (frame === 1'b1) begin
        if (lastF >= 0) begin
          checks++;
          if (c - lastF != FRAME) begin
            failures++;
            $display("[TB] FAIL frame_period got=%0d want=%0d", c - lastF, FRAME);
          end
        end
        lastF = c;
      end
      if (c >= 3 * FRAME && digit !== 4'hF) begin
        checks++;
        if ((digit === 4'hE && segment !== 8'h99) || (digit === 4'hD && segment !== 8'h0D) ||
            (digit === 4'hB && segment !== 8'h25) || (digit === 4'h7 && segment !== 8'h9F)) begin
          failures++;
          $display("[TB] FAIL pattern_1234 digit=%h seg=%h", digit, segment);
        end
      end
    end
  endtask

  task automatic test_blanking();
    value = 16'h00A0; dp = 4'b0100; blank_lz = 1'b1; load = 1'b1;
    for (int c = 0; c < 6 * FRAME; c++) begin
      tick();
      load = 1'b0;
      if (c == 3 * FRAME - 1) begin value = 16'h0000; dp = 4'h0; load = 1'b1; end
      checks++;
      if (digit !== expDigit || segment !== expSeg || frame !== expFrame) begin
        failures++;
        $display("[TB] FAIL blanking c=%0d digit=%h seg=%h frame=%b want %h %h %b", c, digit, segment, frame, expDigit, expSeg, expFrame);
      end
      if (c >= 2 * FRAME && c < 3 * FRAME && digit !== 4'hF) begin
        checks++;
        if ((digit === 4'h7 && segment !== 8'hFF) || (digit === 4'hB && segment !== 8'hFE) ||
            (digit === 4'hD && segment !== 8'h11) || (digit === 4'hE && segment !== 8'h03)) begin
          failures++;
          $display("[TB] FAIL blank_00A0 digit=%h seg=%h", digit, segment);
        end
      end
      if (c >= 5 * FRAME && digit !== 4'hF) begin
        checks++;
        if ((digit === 4'hE && segment !== 8'h03) || (digit !== 4'hE && segment !== 8'hFF)) begin
          failures++;
          $display("[TB] FAIL blank_zero digit=%h seg=%h", digit, segment);
        end
      end
    end
  endtask

  task automatic test_double_buffer();
    bit ok;
    int phase = 0;
    waitFrame(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL dbuf_wait frame=%b want 1", frame); end
    repeat (4) tick();
    blank_lz = 1'b0; dp = 4'h0; value = 16'h1111; load = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      load = 1'b0;
      if (c == 1) begin value = 16'h2222; load = 1'b1; end
      checks++;
      if (digit !== expDigit || segment !== expSeg || frame !== expFrame) begin
        failures++;
        $display("[TB] FAIL dbuf c=%0d digit=%h seg=%h frame=%b want %h %h %b", c, digit, segment, frame, expDigit, expSeg, expFrame);
      end
      if (frame === 1'b1) phase++;
      if (phase == 0 && digit !== 4'hF) begin
        checks++;
        if (segment === 8'h25 || segment === 8'h9F) begin
          failures++;
          $display("[TB] FAIL dbuf_tear seg=%h want old data", segment);
        end
      end
      if (phase == 1 && digit !== 4'hF) begin
        checks++;
        if (segment !== 8'h25) begin
          failures++;
          $display("[TB] FAIL dbuf_last_wins seg=%h want 25", segment);
        end
      end
    end
  endtask

  task automatic test_load_on_frame();
    bit ok;
    logic [15:0] v;
    logic [3:0]  d;
    logic        b;
    waitFrame(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL lof_wait frame=%b want 1", frame); end
    v = 16'($urandom); d = 4'($urandom_range(0, 15)); b = 1'($urandom_range(0, 1));
    value = v; dp = d; blank_lz = b; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (digit !== 4'hE || segment !== refSeg(v, d, b, 0)) begin
      failures++;
      $display("[TB] FAIL load_on_frame digit=%h seg=%h want e %h", digit, segment, refSeg(v, d, b, 0));
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if (digit !== expDigit || segment !== expSeg || frame !== expFrame) begin
        failures++;
        $display("[TB] FAIL lof c=%0d digit=%h seg=%h frame=%b want %h %h %b", c, digit, segment, frame, expDigit, expSeg, expFrame);
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    waitFrame(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL en_wait frame=%b want 1", frame); end
    tick();
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (digit !== 4'hF || segment !== 8'hFF || frame !== 1'b0) begin
        failures++;
        $display("[TB] FAIL enable_dark digit=%h seg=%h frame=%b want f ff 0", digit, segment, frame);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if (digit !== expDigit || segment !== expSeg || frame !== expFrame) begin
        failures++;
        $display("[TB] FAIL enable_resume c=%0d digit=%h seg=%h frame=%b want %h %h %b", c, digit, segment, frame, expDigit, expSeg, expFrame);
      end
      if (c < 3) begin
        checks++;
        if (digit !== ((c < 2) ? 4'hE : 4'hF)) begin
          failures++;
          $display("[TB] FAIL enable_slot c=%0d digit=%h want %h", c, digit, (c < 2) ? 4'hE : 4'hF);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    waitFrame(ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL ar_wait frame=%b want 1", frame); end
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (digit !== 4'hF || segment !== 8'hFF || frame !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset digit=%h seg=%h frame=%b want f ff 0", digit, segment, frame);
    end
    load = 1'b0; blank_lz = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if (digit !== expDigit || segment !== expSeg || frame !== expFrame) begin
        failures++;
        $display("[TB] FAIL after_reset c=%0d digit=%h seg=%h frame=%b want %h %h %b", c, digit, segment, frame, expDigit, expSeg, expFrame);
      end
      if (c == 1) begin
        checks++;
        if (digit !== 4'hE || segment !== 8'h03) begin
          failures++;
          $display("[TB] FAIL restart_digit0 digit=%h seg=%h want e 03", digit, segment);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int c = 0; c < 1200; c++) begin
      tick();
      checks++;
      if (digit !== expDigit || segment !== expSeg || frame !== expFrame) begin
        failures++;
        $display("[TB] FAIL random c=%0d digit=%h seg=%h frame=%b want %h %h %b", c, digit, segment, frame, expDigit, expSeg, expFrame);
      end
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        r = $urandom;
        value = r[15:0] >> (4 * $urandom_range(0, 4));
        dp = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) enable = ~enable;
    end
    enable = 1'b1;
    load = 1'b0;
  endtask

  initial begin
    segTab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    test_reset();
    test_pattern();
    test_blanking();
    test_double_buffer();
    test_load_on_frame();
    test_enable();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Parametrised multiplexed seven-segment display controller. It drives an NDIG-digit common-anode display from a packed hex value, a per-digit decimal-point mask and a leading-zero-blanking option. An internal prescaler and digit counter drive the refresh scan, so upstream logic only supplies data. Loads are double-buffered, so the display never tears mid-frame. The block sits between the count/datapath logic and the board's digit/segment pins.

## Interface
- NDIG, 8: number of digits, 1..16.
- DIV, 50000: clocks per digit slot, ≥2; scan period = NDIG·DIV clocks.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scan runs; 0 = freeze counters and drive display dark.
- load  in  1  one-cycle strobe; captures value/dp/blank_lz into pending buffer.
- value  in  4·NDIG  hex nibbles; nibble k = bits [4k+3:4k] = digit k (digit 0 rightmost).
- dp  in  NDIG  decimal point request per digit, 1 = lit.
- blank_lz  in  1  leading-zero suppression enable.
- digit  out  NDIG  digit selects, active-low, one-hot-zero.
- segment  out  8  bit7..bit0 = a,b,c,d,e,f,g,dp; active-low (0 = lit).
- frame  out  1  one-cycle pulse at each frame start.

## Operation
- Reset values: digit all 1s, segment 8'hFF, frame 0, prescaler 0, index 0, pending and active buffers all 0 (value, dp, blank_lz).
- Prescaler p counts 0..DIV-1 and wraps. At wrap, index i advances 0→1→…→NDIG-1→0.
- Index width = max(1, clog2(NDIG)).
- Decode table (nibble → segment): 0 03, 1 9F, 2 25, 3 0D, 4 99, 5 49, 6 41, 7 1F, 8 01, 9 09, A 11, b C1, C 63, d 85, E 61, F 71. Bit0 is cleared when dp[i] is set.
- Leading-zero blanking: digit k>0 is blanked (segment FF, dp still honoured) when blank_lz is set and nibbles k..NDIG-1 are all zero. Digit 0 is never blanked.
- Double buffer: load copies inputs into pending. At frame start (i wraps to 0 with p=0), pending is copied to active. The display decodes only from active.
- If load coincides with a frame-start transfer, the newly loaded data goes directly to active.
- Multiple loads within a frame: the last one wins.
- enable=0: p and i hold, frame=0, digit all 1s, segment FF. Loads are still accepted into pending.
- On enable returning to 1, the scan resumes from the held p and i.
- Reset mid-frame returns to the reset state immediately (asynchronous); the first slot after release is digit 0.

## Timing
- All outputs are registered.
- Each slot lasts DIV clocks. On the first clock of the slot (p=0), outputs are dead-time: digit all 1s, segment FF. This is anti-ghosting.
- On the remaining DIV-1 clocks of the slot, digit[i]=0, other digit bits are 1, and segment = decode(active nibble i).
- Output latency: one clock after the prescaler/index state changes.
- frame goes high for exactly one clock, coincident with the dead-time clock of slot 0 of every frame after reset.
- frame does not pulse on the very first frame after reset.
- Data latency: a load lands on the display no later than the next frame start; worst case is NDIG·DIV+1 clocks.

## Test plan
- NDIG=4, DIV=4, enable=1, load value=16'h1234, dp=0 → per frame digit sequence E,D,B,7. Each select is active for 3 clocks after a 1-clock all-off gap. Segments 4=99, 3=0D, 2=25, 1=9F. frame period = 16 clocks.
- Load value=16'h00A0, blank_lz=1, dp=4'b0100 → digit 3 FF; digit 2 FE (dp only); digit 1 11; digit 0 03. With value=0, digits 1..3 are FF and digit 0 is 03.
- Load 16'h1111 mid-frame, then 16'h2222 two clocks later → remainder of the current frame still shows the old value; the next frame shows all 25, never 9F.
- Load asserted on the same clock as frame → the new value is visible in digit 0 of that frame.
- Drop enable for 10 clocks mid-slot → outputs dark with frame=0. On resume, the same digit completes its remaining clocks.
- Assert rst asynchronously mid-slot → digit FFFF and segment FF before the next edge. After release, the scan restarts at digit 0 showing 03 (zero buffers, blank_lz=0).
